sys_seq_arb: RTL and testbench

Job sequencer and bus arbiter placed between the CPU data-bus port and the systolic array's I/O buffer bus.
- Accepts a job descriptor: max counter and run counter.
- Programs the count registers (0xFFF1, 0xFFF2), fires the one-shot start (0xFFF0), then polls run status at 0xFFF0 until the array finishes, and raises a sticky interrupt.
- Between sequencer accesses, the CPU gets pass-through access to the same bus, so it can load A/B buffers and read S buffers.

---
 rtl/sys_seq_arb.sv | 179 +++++++++++++++++
 tb/tb_sys_seq_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_seq_arb.sv
// rtl/sys_seq_arb.sv - job sequencer and CPU/sequencer bus arbiter (optional watchdog: SEQ_TIMEOUT_EN)
module sys_seq_arb #(
    parameter int          STAT_LAT = 1,
    parameter int          RD_LAT   = 2,
    parameter int          POLL_GAP = 4,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_ren,
    input  logic [15:0] c_radr,
    input  logic        c_wen,
    input  logic [15:0] c_wadr,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_stall,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_max,
    input  logic [7:0]  job_run,
    output logic        irq,
    input  logic        irq_clr,
    output logic        err,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata
);

    typedef enum logic [2:0] {IDLE, WMAX, WRUN, WSTART, GAP, POLL, WAIT, DONE} state_t;

    // Only reads granted 1..RD_LAT-1 cycles ago can still land inside a poll's WAIT window.
    localparam logic [RD_LAT-1:0] INFL_MASK = RD_LAT'((64'd1 << (RD_LAT - 1)) - 64'd1);
    localparam logic [15:0]       GAP_LOAD  = 16'(POLL_GAP);
    localparam logic [15:0]       STAT_LOAD = 16'(STAT_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [7:0]        jmax;
    logic [7:0]        jrun;
    logic [RD_LAT-1:0] infl;
    logic              owned;
    logic              rd_grant;
    logic              rd_busy;
    logic              tmo;
    logic              set_irq;
    logic              irq_r;

    assign owned     = (state == WMAX) || (state == WRUN) || (state == WSTART) ||
                       (state == POLL) || (state == WAIT);
    assign rd_grant  = c_ren & ~owned;
    assign rd_busy   = rd_grant | (|(infl & INFL_MASK));
    assign job_ready = (state == IDLE);
    assign c_rdata   = ibus_rdata;
    assign set_irq   = (state == DONE) | tmo;
    assign irq       = irq_r;

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] tcnt;
    logic        err_r;
    logic        polling;

    assign polling = (state == GAP) || (state == POLL) || (state == WAIT);
    assign tmo     = polling && (tcnt == TIMEOUT);
    assign err     = err_r;

    // Watchdog: restarts when the job is fired, counts every cycle spent polling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tcnt <= 16'd0;
        else if (state == WSTART) tcnt <= 16'd0;
        else if (polling)         tcnt <= tcnt + 16'd1;
    end

    // Sticky timeout flag; a new timeout wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_r <= 1'b0;
        else if (tmo)     err_r <= 1'b1;
        else if (irq_clr) err_r <= 1'b0;
    end
`else
    logic unused_cfg;
    assign unused_cfg = &{1'b0, TIMEOUT};
    assign tmo        = 1'b0;
    assign err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the job descriptor when it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jmax <= 8'd0;
            jrun <= 8'd0;
        end else if (state == IDLE && job_valid) begin
            jmax <= job_max;
            jrun <= job_run;
        end
    end

    // Shared down-counter: GAP length on entry to GAP, status latency on entry to WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 cnt <= 16'd0;
        else if (state_nxt == GAP && state != GAP)   cnt <= GAP_LOAD;
        else if (state_nxt == WAIT && state != WAIT) cnt <= STAT_LOAD;
        else if (cnt != 16'd0)                      cnt <= cnt - 16'd1;
    end

    // History of granted CPU reads whose data may still be on its way back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) infl <= '0;
        else        infl <= (infl << 1) | RD_LAT'(rd_grant);
    end

    // Sticky completion flag; setting wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       irq_r <= 1'b0;
        else if (set_irq) irq_r <= 1'b1;
        else if (irq_clr) irq_r <= 1'b0;
    end

    // Next state, sequencer bus cycles and CPU pass-through/stall.
    always_comb begin
        state_nxt  = state;
        ren        = 1'b0;
        ibus_radr  = 16'd0;
        wen        = 1'b0;
        ibus_wadr  = 16'd0;
        ibus_wdata = 16'd0;
        c_stall    = 1'b0;
        case (state)
            IDLE: if (job_valid) state_nxt = WMAX;
            WMAX: begin
                wen        = 1'b1;
                ibus_wadr  = 16'hFFF1;
                ibus_wdata = {8'd0, jmax};
                state_nxt  = WRUN;
            end
            WRUN: begin
                wen        = 1'b1;
                ibus_wadr  = 16'hFFF2;
                ibus_wdata = {8'd0, jrun};
                state_nxt  = WSTART;
            end
            WSTART: begin
                wen        = 1'b1;
                ibus_wadr  = 16'hFFF0;
                ibus_wdata = 16'h0001;
                state_nxt  = GAP;
            end
            GAP: if (cnt <= 16'd1 && !rd_busy) state_nxt = POLL;
            POLL: begin
                ren       = 1'b1;
                ibus_radr = 16'hFFF0;
                state_nxt = WAIT;
            end
            WAIT: if (cnt == 16'd0) state_nxt = ibus_rdata[0] ? GAP : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (owned) begin
            c_stall = c_ren | c_wen;
        end else begin
            ren        = c_ren;
            ibus_radr  = c_ren ? c_radr : 16'd0;
            wen        = c_wen;
            ibus_wadr  = c_wen ? c_wadr : 16'd0;
            ibus_wdata = c_wen ? c_wdata : 16'd0;
        end
        if (tmo) state_nxt = IDLE;
    end

endmodule

// File: tb/tb_sys_seq_arb.sv
// tb/tb_sys_seq_arb.sv - directed self-checking bench for sys_seq_arb
module tb_sys_seq_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_ren;
    logic [15:0] c_radr;
    logic        c_wen;
    logic [15:0] c_wadr;
    logic [15:0] c_wdata;
    logic [15:0] c_rdata;
    logic        c_stall;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_max;
    logic [7:0]  job_run;
    logic        irq;
    logic        irq_clr;
    logic        err;
    logic        ren;
    logic [15:0] ibus_radr;
    logic [15:0] ibus_rdata = 16'd0;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int npoll = 0;
    int poll_base = 0;
    int busy_polls = 0;
    int poll_q[$];
    int t;
    logic s_pipe = 1'b0;

    always #5 clk = ~clk;

    sys_seq_arb #(
        .STAT_LAT(1),
        .RD_LAT  (2),
        .POLL_GAP(4),
        .TIMEOUT (16'd40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_ren     (c_ren),
        .c_radr    (c_radr),
        .c_wen     (c_wen),
        .c_wadr    (c_wadr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_max   (job_max),
        .job_run   (job_run),
        .irq       (irq),
        .irq_clr   (irq_clr),
        .err       (err),
        .ren       (ren),
        .ibus_radr (ibus_radr),
        .ibus_rdata(ibus_rdata),
        .wen       (wen),
        .ibus_wadr (ibus_wadr),
        .ibus_wdata(ibus_wdata)
    );

    // Array/buffer model: status returns 1 cycle after a poll, S-buffer reads 2 cycles after.
    always @(posedge clk) begin
        s_pipe <= ren && (ibus_radr == 16'h8000);
        if (ren && ibus_radr == 16'hFFF0) begin
            ibus_rdata <= ((npoll - poll_base) < busy_polls) ? 16'h0001 : 16'h0000;
            npoll      <= npoll + 1;
        end else if (s_pipe) begin
            ibus_rdata <= 16'hBEEF;
        end else begin
            ibus_rdata <= 16'h0000;
        end
    end

    // Cycle index and poll-read log.
    always @(negedge clk) begin
        if (ren && ibus_radr == 16'hFFF0) poll_q.push_back(cyc);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            next_cycle();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; c_ren = 1'b0; c_radr = 16'd0; c_wen = 1'b0; c_wadr = 16'd0;
        c_wdata = 16'd0; job_valid = 1'b0; job_max = 8'd0; job_run = 8'd0; irq_clr = 1'b0;
        repeat (3) next_cycle();
        #1;
        check("rst_ready", job_ready, 1);
        check("rst_irq", irq, 0);
        check("rst_err", err, 0);
        check("rst_ren", ren, 0);
        check("rst_wen", wen, 0);
        check("rst_stall", c_stall, 0);
        check("rst_radr", ibus_radr, 0);
        check("rst_wadr", ibus_wadr, 0);
        check("rst_wdata", ibus_wdata, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Job 1: three busy polls then done; CPU write stalled in WRUN lands in GAP.
        next_cycle();
        t = cyc; poll_base = npoll; busy_polls = 3; poll_q.delete();
        job_valid = 1'b1; job_max = 8'd8; job_run = 8'd5;
        c_wen = 1'b1; c_wadr = 16'h0010; c_wdata = 16'h1234;
        #1;
        check("idle_ready", job_ready, 1);
        check("idle_cpu_wen", wen, 1);
        check("idle_cpu_wadr", ibus_wadr, 16'h0010);
        check("idle_cpu_wdata", ibus_wdata, 16'h1234);
        check("idle_stall", c_stall, 0);
        next_cycle();
        job_valid = 1'b0; job_max = 8'hFF; job_run = 8'hFF; c_wen = 1'b0;
        #1;
        check("wmax_wen", wen, 1);
        check("wmax_wadr", ibus_wadr, 16'hFFF1);
        check("wmax_wdata", ibus_wdata, 16'h0008);
        check("wmax_ready", job_ready, 0);
        next_cycle();
        c_wen = 1'b1; c_wadr = 16'h0005; c_wdata = 16'hA5A5;
        #1;
        check("wrun_wadr", ibus_wadr, 16'hFFF2);
        check("wrun_wdata", ibus_wdata, 16'h0005);
        check("wrun_stall", c_stall, 1);
        next_cycle(); #1;
        check("wstart_wadr", ibus_wadr, 16'hFFF0);
        check("wstart_wdata", ibus_wdata, 16'h0001);
        check("wstart_stall", c_stall, 1);
        next_cycle(); #1;
        check("gap_cpu_wen", wen, 1);
        check("gap_cpu_wadr", ibus_wadr, 16'h0005);
        check("gap_cpu_wdata", ibus_wdata, 16'hA5A5);
        check("gap_stall", c_stall, 0);
        c_wen = 1'b0;
        run_to(t + 28); #1;
        check("done_irq_low", irq, 0);
        irq_clr = 1'b1;
        next_cycle(); #1;
        check("irq_set_beats_clr", irq, 1);
        check("job1_ready", job_ready, 1);
        next_cycle();
        irq_clr = 1'b0;
        #1;
        check("irq_cleared", irq, 0);
        check("job1_npolls", poll_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("job1_poll%0d", i), (i < poll_q.size()) ? poll_q[i] : -1, t + 8 + 6 * i);

        // Job 2: CPU S-buffer read in the last GAP cycle defers the poll.
        next_cycle();
        t = cyc; poll_base = npoll; busy_polls = 1; poll_q.delete();
        job_valid = 1'b1; job_max = 8'd3; job_run = 8'd2;
        next_cycle();
        job_valid = 1'b0;
        run_to(t + 7);
        c_ren = 1'b1; c_radr = 16'h8000;
        #1;
        check("sread_ren", ren, 1);
        check("sread_radr", ibus_radr, 16'h8000);
        check("sread_stall", c_stall, 0);
        next_cycle();
        c_ren = 1'b0;
        #1;
        check("defer_a_ren", ren, 0);
        next_cycle(); #1;
        check("defer_b_ren", ren, 0);
        check("sread_data", c_rdata, 16'hBEEF);
        next_cycle(); #1;
        check("poll_deferred_ren", ren, 1);
        check("poll_deferred_radr", ibus_radr, 16'hFFF0);
        run_to(t + 18); #1;
        check("job2_irq_early", irq, 0);
        next_cycle(); #1;
        check("job2_irq", irq, 1);
        check("job2_ready", job_ready, 1);
        check("job2_npolls", poll_q.size(), 2);
        check("job2_poll1", (poll_q.size() > 1) ? poll_q[1] : -1, t + 16);

        // Job 3: asynchronous reset in WRUN drops the bus cycle and clears irq.
        next_cycle();
        t = cyc;
        job_valid = 1'b1;
        next_cycle();
        job_valid = 1'b0;
        next_cycle(); #1;
        check("wrun_pre_rst_wen", wen, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wen", wen, 0);
        check("midrst_wadr", ibus_wadr, 0);
        check("midrst_ready", job_ready, 1);
        check("midrst_irq", irq, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Job 4: status stuck busy.
        next_cycle();
        t = cyc; poll_base = npoll; busy_polls = 1000;
        job_valid = 1'b1; job_max = 8'd1; job_run = 8'd1;
        next_cycle();
        job_valid = 1'b0;
        run_to(t + 44); #1;
        check("tmo_err_early", err, 0);
        check("tmo_irq_early", irq, 0);
        next_cycle(); #1;
`ifdef SEQ_TIMEOUT_EN
        check("tmo_err", err, 1);
        check("tmo_irq", irq, 1);
        check("tmo_ready", job_ready, 1);
        run_to(t + 50); #1;
        check("tmo_no_poll", ren, 0);
        irq_clr = 1'b1;
        next_cycle();
        irq_clr = 1'b0;
        #1;
        check("tmo_err_clr", err, 0);
        check("tmo_irq_clr", irq, 0);
`else
        check("notmo_err", err, 0);
        check("notmo_irq", irq, 0);
        check("notmo_ready", job_ready, 0);
        run_to(t + 50); #1;
        check("notmo_poll_ren", ren, 1);
        check("notmo_poll_radr", ibus_radr, 16'hFFF0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
`endif
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
